hls_run_sequencer: RTL

- Run controller for one Bambu-generated accelerator top (`main`).
- Loads N_WORDS 32-bit input words into accelerator memory through the slave RAM port, channel 0.
- Pulses start_port, measures latency until done_port, applies a timeout watchdog, then reads the N_WORDS results back and streams them out.
- Replaces the file-driven simulation flow with synthesizable on-board sequencing, e.g. for bsort100 with N_WORDS=100.

---
 rtl/hls_run_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hls_run_sequencer.sv
// Run controller for a Bambu-generated accelerator: loads input words through
// slave RAM channel 0, starts the accelerator, times the run under a watchdog,
// then reads the results back and streams them out.
module hls_run_sequencer #(
   parameter int unsigned N_WORDS        = 100,
   parameter int unsigned BASE_ADDR      = 0,
   parameter int unsigned ADDR_W         = 9,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned SIZE_W         = 7,
   parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_start,
   output logic                  cmd_ready,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_data,
   output logic                  busy,
   output logic                  run_done,
   output logic                  timeout_err,
   output logic [31:0]           run_cycles,
   output logic                  start_port,
   input  logic                  done_port,
   output logic [1:0]            S_oe_ram,
   output logic [1:0]            S_we_ram,
   output logic [2*ADDR_W-1:0]   S_addr_ram,
   output logic [2*DATA_W-1:0]   S_Wdata_ram,
   output logic [2*SIZE_W-1:0]   S_data_ram_size,
   input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
   input  logic [1:0]            Sout_DataRdy
);

   localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_WORDS - 1);
   localparam logic [31:0]       TIMEOUT  = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0]       CNT_MAX  = '1;
   localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(BASE_ADDR);
   localparam logic [SIZE_W-1:0] ACC_SIZE = SIZE_W'(32);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_WR, S_START, S_RUN, S_RD, S_OUT, S_DONE, S_TOUT
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic [31:0]       cnt_q, cnt_d, cnt_inc;
   logic [31:0]       run_cycles_q, run_cycles_d;
   logic              tout_q, tout_d;
   logic [31:0]       out_data_q, out_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              in_ready_q, out_valid_q, run_done_q, start_q, oe_q, we_q;
   logic              unused_inputs;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      word_d       = word_q;
      cnt_d        = cnt_q;
      run_cycles_d = run_cycles_q;
      tout_d       = tout_q;
      out_data_d   = out_data_q;
      cnt_inc      = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 32'd1;

      case (state_q)
         S_IDLE, S_DONE, S_TOUT: begin
            if (cmd_start) begin
               idx_d   = '0;
               tout_d  = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               word_d  = in_data;
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (Sout_DataRdy[0]) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_START;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_START: begin
            cnt_d   = 32'd1;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            // done wins over a timeout reached in the same cycle
            if (done_port) begin
               run_cycles_d = cnt_inc;
               idx_d        = '0;
               state_d      = S_RD;
            end else if (cnt_inc >= TIMEOUT) begin
               run_cycles_d = TIMEOUT;
               tout_d       = 1'b1;
               state_d      = S_TOUT;
            end
         end
         S_RD: begin
            if (Sout_DataRdy[0]) begin
               out_data_d = Sout_Rdata_ram[31:0];
               state_d    = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_RD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      addr_d      = ADDR_W'(BASE_ADDR + (32'(idx_d) << 2));
      cmd_ready_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_TOUT);
   end

   // State, datapath and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         word_q       <= '0;
         cnt_q        <= '0;
         run_cycles_q <= '0;
         tout_q       <= 1'b0;
         out_data_q   <= '0;
         addr_q       <= ADDR_RST;
         cmd_ready_q  <= 1'b1;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         run_done_q   <= 1'b0;
         start_q      <= 1'b0;
         oe_q         <= 1'b0;
         we_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         run_cycles_q <= run_cycles_d;
         tout_q       <= tout_d;
         out_data_q   <= out_data_d;
         addr_q       <= addr_d;
         cmd_ready_q  <= cmd_ready_d;
         in_ready_q   <= (state_d == S_LOAD);
         out_valid_q  <= (state_d == S_OUT);
         run_done_q   <= (state_d == S_DONE) && (state_q != S_DONE);
         start_q      <= (state_d == S_START);
         oe_q         <= (state_d == S_RD);
         we_q         <= (state_d == S_WR);
      end
   end

   assign cmd_ready       = cmd_ready_q;
   assign busy            = ~cmd_ready_q;
   assign in_ready        = in_ready_q;
   assign out_valid       = out_valid_q;
   assign out_data        = out_data_q;
   assign run_done        = run_done_q;
   assign timeout_err     = tout_q;
   assign run_cycles      = run_cycles_q;
   assign start_port      = start_q;
   // Channel 1 is never used; channel 0 occupies the low half of each bus
   assign S_oe_ram        = {1'b0, oe_q};
   assign S_we_ram        = {1'b0, we_q};
   assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
   assign S_Wdata_ram     = {{DATA_W{1'b0}}, DATA_W'(word_q)};
   assign S_data_ram_size = {{SIZE_W{1'b0}}, ACC_SIZE};

   assign unused_inputs = ^{Sout_DataRdy[1], Sout_Rdata_ram[2*DATA_W-1:32]};

endmodule
